// File: rtl/dm_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dm_arbiter                                                             |
// | Round-robin CPU/IO arbiter and access sequencer for the data memory.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module dm_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int LAST_OK = 4092
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_wr,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic              io_err,
  output logic [DATA_W-1:0] io_rdata,
  output logic              dm_cs,
  output logic              dm_wr,
  output logic              dm_rd,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  input  logic [DATA_W-1:0] dm_dout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_OK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_io_q, last_io_d;
  logic                dm_cs_q, dm_cs_d;
  logic                dm_wr_q, dm_wr_d;
  logic                dm_rd_q, dm_rd_d;
  logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0]   dm_din_q, dm_din_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                cpu_err_q, cpu_err_d;
  logic                io_ack_q, io_ack_d;
  logic                io_err_q, io_err_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   io_rdata_q, io_rdata_d;

  logic                grant_io;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_legal;

  // last_io_q doubles as the identity of the port currently being served.
  always_comb begin
    grant_io  = io_req && (!cpu_req || !last_io_q);
    sel_wr    = grant_io ? io_wr    : cpu_wr;
    sel_addr  = grant_io ? io_addr  : cpu_addr;
    sel_wdata = grant_io ? io_wdata : cpu_wdata;
    sel_legal = (sel_addr <= LAST_ADDR);
  end

  always_comb begin
    state_d     = state_q;
    last_io_d   = last_io_q;
    dm_cs_d     = 1'b0;
    dm_wr_d     = 1'b0;
    dm_rd_d     = 1'b0;
    dm_addr_d   = dm_addr_q;
    dm_din_d    = dm_din_q;
    cpu_ack_d   = 1'b0;
    cpu_err_d   = 1'b0;
    io_ack_d    = 1'b0;
    io_err_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || io_req) begin
          last_io_d = grant_io;
          if (sel_legal) begin
            state_d   = ACCESS;
            dm_cs_d   = 1'b1;
            dm_wr_d   = sel_wr;
            dm_rd_d   = !sel_wr;
            dm_addr_d = sel_addr;
            dm_din_d  = sel_wdata;
          end else begin
            // Out-of-range access never reaches the memory pins.
            state_d   = DONE;
            cpu_ack_d = !grant_io;
            cpu_err_d = !grant_io;
            io_ack_d  = grant_io;
            io_err_d  = grant_io;
          end
        end
      end
      ACCESS: begin
        state_d   = DONE;
        cpu_ack_d = !last_io_q;
        io_ack_d  = last_io_q;
        if (dm_rd_q) begin
          if (last_io_q) io_rdata_d  = dm_dout;
          else           cpu_rdata_d = dm_dout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_io_q   <= 1'b1;
      dm_cs_q     <= 1'b0;
      dm_wr_q     <= 1'b0;
      dm_rd_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_din_q    <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      io_ack_q    <= 1'b0;
      io_err_q    <= 1'b0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_io_q   <= last_io_d;
      dm_cs_q     <= dm_cs_d;
      dm_wr_q     <= dm_wr_d;
      dm_rd_q     <= dm_rd_d;
      dm_addr_q   <= dm_addr_d;
      dm_din_q    <= dm_din_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
      io_ack_q    <= io_ack_d;
      io_err_q    <= io_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign io_ack    = io_ack_q;
  assign io_err    = io_err_q;
  assign io_rdata  = io_rdata_q;
  assign dm_cs     = dm_cs_q;
  assign dm_wr     = dm_wr_q;
  assign dm_rd     = dm_rd_q;
  assign dm_addr   = dm_addr_q;
  assign dm_din    = dm_din_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_dm_arbiter                                                          |
// | Self-checking bench: byte memory, timeline reference model, stimulus.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_dm_arbiter;
  localparam int LAST_OK = 4092;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_wr, io_req, io_wr;
  logic [11:0] cpu_addr, io_addr;
  logic [31:0] cpu_wdata, io_wdata;
  logic        cpu_ack, cpu_err, io_ack, io_err;
  logic [31:0] cpu_rdata, io_rdata;
  logic        dm_cs, dm_wr, dm_rd;
  logic [11:0] dm_addr;
  logic [31:0] dm_din, dm_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(12), .DATA_W(32), .LAST_OK(LAST_OK)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_err(io_err), .io_rdata(io_rdata),
    .dm_cs(dm_cs), .dm_wr(dm_wr), .dm_rd(dm_rd), .dm_addr(dm_addr),
    .dm_din(dm_din), .dm_dout(dm_dout)
  );

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 7) + 3);
  endfunction

  // Big-endian byte memory; junk on the bus whenever it is not being read.
  logic [7:0] mem [4096];
  bit         mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_byte(i);
      mem_ready <= 1'b1;
    end else if (dm_cs && dm_wr) begin
      mem[dm_addr]         <= dm_din[31:24];
      mem[dm_addr + 12'd1] <= dm_din[23:16];
      mem[dm_addr + 12'd2] <= dm_din[15:8];
      mem[dm_addr + 12'd3] <= dm_din[7:0];
    end
  end

  always_comb begin
    dm_dout = 32'hBAD0_BAD0;
    if (dm_cs && dm_rd)
      dm_dout = {mem[dm_addr], mem[dm_addr + 12'd1], mem[dm_addr + 12'd2], mem[dm_addr + 12'd3]};
  end

  // Reference model: a transaction timeline indexed by rising-edge number.
  logic [7:0]  shadow [4096];
  int          n_edge = 0;
  int          free_edge = 0;
  int          ack_edge = -1;
  bit          pend = 0;
  bit          last_io_m = 1;
  int          pw = 0;
  bit          p_wr = 0;
  logic [31:0] p_rdval = '0;
  logic        e_cs, e_wr, e_rd;
  logic [11:0] e_addr;
  logic [31:0] e_din;
  logic [1:0]  e_ack, e_err;
  logic [31:0] e_rdata [2];

  task automatic model_step();
    bit          w;
    logic [11:0] a;
    logic [31:0] d;
    n_edge++;
    if (!reset_n) begin
      e_cs = 0; e_wr = 0; e_rd = 0; e_addr = '0; e_din = '0;
      e_ack = '0; e_err = '0; e_rdata[0] = '0; e_rdata[1] = '0;
      last_io_m = 1; pend = 0; free_edge = n_edge + 1;
      return;
    end
    e_cs = 0; e_wr = 0; e_rd = 0; e_ack = '0; e_err = '0;
    if (pend && n_edge == ack_edge) begin
      e_ack[pw] = 1'b1;
      if (!p_wr) e_rdata[pw] = p_rdval;
      pend = 0;
    end
    if (n_edge >= free_edge && (cpu_req || io_req)) begin
      pw = (cpu_req && (!io_req || last_io_m)) ? 0 : 1;
      last_io_m = (pw == 1);
      w = (pw == 1) ? io_wr : cpu_wr;
      a = (pw == 1) ? io_addr : cpu_addr;
      d = (pw == 1) ? io_wdata : cpu_wdata;
      if (int'(a) > LAST_OK) begin
        e_ack[pw] = 1'b1; e_err[pw] = 1'b1; free_edge = n_edge + 2;
      end else begin
        e_cs = 1; e_wr = w; e_rd = !w; e_addr = a; e_din = d;
        pend = 1; p_wr = w; ack_edge = n_edge + 1; free_edge = n_edge + 3;
        if (w) begin
          for (int k = 0; k < 4; k++) shadow[int'(a) + k] = d[31 - 8 * k -: 8];
        end else begin
          p_rdval = {shadow[int'(a)], shadow[int'(a) + 1], shadow[int'(a) + 2], shadow[int'(a) + 3]};
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    chk("dm_cs", 32'(dm_cs), 32'(e_cs));
    chk("dm_wr", 32'(dm_wr), 32'(e_wr));
    chk("dm_rd", 32'(dm_rd), 32'(e_rd));
    chk("dm_addr", 32'(dm_addr), 32'(e_addr));
    chk("dm_din", dm_din, e_din);
    chk("cpu_ack", 32'(cpu_ack), 32'(e_ack[0]));
    chk("cpu_err", 32'(cpu_err), 32'(e_err[0]));
    chk("io_ack", 32'(io_ack), 32'(e_ack[1]));
    chk("io_err", 32'(io_err), 32'(e_err[1]));
    chk("cpu_rdata", cpu_rdata, e_rdata[0]);
    chk("io_rdata", io_rdata, e_rdata[1]);
  endtask

  task automatic drive(input int p, input bit rq, input bit w, input logic [11:0] a, input logic [31:0] d);
    if (p == 0) begin cpu_req = rq; cpu_wr = w; cpu_addr = a; cpu_wdata = d; end
    else        begin io_req = rq;  io_wr = w;  io_addr = a;  io_wdata = d;  end
  endtask

  function automatic bit ack_of(input int p);
    return (p == 0) ? (cpu_ack === 1'b1) : (io_ack === 1'b1);
  endfunction

  function automatic bit err_of(input int p);
    return (p == 0) ? (cpu_err === 1'b1) : (io_err === 1'b1);
  endfunction

  task automatic wait_ack(input int p, output int lat, output bit cs_seen, output bit err_seen);
    lat = 0; cs_seen = 0; err_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      lat++;
      if (dm_cs) cs_seen = 1;
      if (ack_of(p)) begin
        err_seen = err_of(p);
        return;
      end
    end
    checks++; failures++;
    $display("FAIL ack_timeout: port %0d got no ack, required within 20 cycles", p);
    lat = -1;
  endtask

  task automatic op(input int p, input bit w, input logic [11:0] a, input logic [31:0] d,
                    output int lat, output bit cs_seen, output bit err_seen);
    drive(p, 1, w, a, d);
    wait_ack(p, lat, cs_seen, err_seen);
    drive(p, 0, 0, a, d);
    tick();
  endtask

  task automatic rand_req(input int p);
    logic [11:0] a;
    if ($urandom_range(3, 0) == 0) a = 12'(4090 + $urandom_range(5, 0));
    else                           a = 12'($urandom);
    drive(p, 1, 1'($urandom_range(1, 0)), a, $urandom);
  endtask

  initial begin
    int          lat;
    bit          cs, er;
    int          cnt, simul;
    logic [11:0] seq [4];
    bit          busy [2];
    int          wcnt [2];

    for (int i = 0; i < 4096; i++) shadow[i] = init_byte(i);

    // Reset held two cycles with both ports requesting.
    reset_n = 0;
    drive(0, 1, 0, 12'h020, 32'h0);
    drive(1, 1, 0, 12'h040, 32'h0);
    tick();
    chk("rst_dm_cs", 32'(dm_cs), 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_io_ack", 32'(io_ack), 32'h0);
    tick();
    chk("rst_dm_addr", 32'(dm_addr), 32'h0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    reset_n = 1;
    tick();
    chk("first_grant_cs", 32'(dm_cs), 32'h1);
    chk("first_grant_cpu", 32'(dm_addr), 32'h020);
    wait_ack(0, lat, cs, er);
    drive(0, 0, 0, 12'h0, 32'h0);
    wait_ack(1, lat, cs, er);
    drive(1, 0, 0, 12'h0, 32'h0);
    tick();

    // CPU write then read.
    op(0, 1, 12'h010, 32'h1122_3344, lat, cs, er);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("mem_010", 32'(mem[12'h010]), 32'h11);
    chk("mem_013", 32'(mem[12'h013]), 32'h44);
    op(0, 0, 12'h010, 32'h0, lat, cs, er);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_010", cpu_rdata, 32'h1122_3344);

    // Unaligned and edge addresses.
    op(0, 0, 12'h011, 32'h0, lat, cs, er);
    chk("rd_011_unaligned", cpu_rdata, 32'h2233_448F);
    op(0, 1, 12'd4092, 32'hA5A5_0F0F, lat, cs, er);
    chk("wr_4092_err", 32'(er), 32'h0);
    chk("mem_4095", 32'(mem[12'd4095]), 32'h0F);
    op(0, 0, 12'd4093, 32'h0, lat, cs, er);
    chk("ill_latency", 32'(lat), 32'd1);
    chk("ill_err", 32'(er), 32'h1);
    chk("ill_no_cs", 32'(cs), 32'h0);
    chk("ill_rdata_kept", cpu_rdata, 32'h2233_448F);
    op(0, 0, 12'h010, 32'h0, lat, cs, er);

    // Port isolation.
    op(1, 1, 12'h200, 32'h0000_CAFE, lat, cs, er);
    op(1, 0, 12'h200, 32'h0, lat, cs, er);
    chk("iso_io_rdata", io_rdata, 32'h0000_CAFE);
    chk("iso_cpu_rdata", cpu_rdata, 32'h1122_3344);

    // Contention: both ports held for 12 cycles.
    drive(0, 1, 0, 12'h300, 32'h0);
    drive(1, 1, 0, 12'h380, 32'h0);
    cnt = 0; simul = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (dm_cs === 1'b1) begin
        if (cnt < 4) seq[cnt] = dm_addr;
        cnt++;
      end
      if (cpu_ack === 1'b1 && io_ack === 1'b1) simul++;
    end
    drive(0, 0, 0, 12'h0, 32'h0);
    drive(1, 0, 0, 12'h0, 32'h0);
    tick();
    chk("cont_grants", 32'(cnt), 32'd4);
    if (cnt >= 4) begin
      chk("cont_g0_cpu", 32'(seq[0]), 32'h300);
      chk("cont_g1_io", 32'(seq[1]), 32'h380);
      chk("cont_g2_cpu", 32'(seq[2]), 32'h300);
      chk("cont_g3_io", 32'(seq[3]), 32'h380);
    end
    chk("cont_simul_ack", 32'(simul), 32'h0);

    // Reset landing in the ACCESS cycle of an IO write.
    drive(1, 1, 1, 12'h100, 32'hDEAD_BEEF);
    tick();
    chk("mid_wr_access", 32'(dm_wr), 32'h1);
    reset_n = 0;
    drive(1, 0, 0, 12'h0, 32'h0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (io_ack === 1'b1) cnt++;
      reset_n = 1;
    end
    chk("mid_wr_no_ack", 32'(cnt), 32'h0);
    op(0, 0, 12'h100, 32'h0, lat, cs, er);
    chk("mid_wr_commit", cpu_rdata, 32'hDEAD_BEEF);

    // Randomised traffic with occasional resets.
    busy[0] = 0; busy[1] = 0; wcnt[0] = 0; wcnt[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (!reset_n) reset_n = 1;
      else if ($urandom_range(299, 0) == 0) reset_n = 0;
      for (int p = 0; p < 2; p++) begin
        if (busy[p]) begin
          if (ack_of(p)) begin
            wcnt[p] = 0;
            if ($urandom_range(1, 0) == 1) rand_req(p);
            else begin drive(p, 0, 0, 12'h0, 32'h0); busy[p] = 0; end
          end else begin
            wcnt[p]++;
            if (wcnt[p] > 40) begin
              checks++; failures++;
              $display("FAIL rand_ack_timeout: port %0d waited %0d cycles, required at most 40", p, wcnt[p]);
              wcnt[p] = 0;
            end
          end
        end else if ($urandom_range(2, 0) == 0) begin
          rand_req(p);
          busy[p] = 1;
          wcnt[p] = 0;
        end
      end
    end
    drive(0, 0, 0, 12'h0, 32'h0);
    drive(1, 0, 0, 12'h0, 32'h0);
    reset_n = 1;
    for (int k = 0; k < 5; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
